// File: rtl/g_reg_file_sb_if.sv
// Decode/write-back side bundle of the scoreboarded register file.
// The master side drives indices, reserves and write-backs; the slave side returns operands and status.
interface g_reg_file_sb_if #(
    parameter int unsigned W_OPR = 32,
    parameter int unsigned W_RD  = 4
);
    logic [W_RD-1:0]  r0_i;
    logic [W_RD-1:0]  r1_i;
    logic [W_OPR-1:0] r_opr0_o;
    logic [W_OPR-1:0] r_opr1_o;
    logic             reserved_o;
    logic             rsv_i;
    logic [W_RD-1:0]  rsv_r_i;
    logic             rsv_full_o;
    logic             wb0_i;
    logic [W_RD-1:0]  wb0_r_i;
    logic [W_OPR-1:0] result0_i;
    logic             wb1_i;
    logic [W_RD-1:0]  wb1_r_i;
    logic [W_OPR-1:0] result1_i;
    logic             flush_i;
    logic             busy_o;

    modport master (
        output r0_i, r1_i, rsv_i, rsv_r_i, wb0_i, wb0_r_i, result0_i,
               wb1_i, wb1_r_i, result1_i, flush_i,
        input  r_opr0_o, r_opr1_o, reserved_o, rsv_full_o, busy_o
    );

    modport slave (
        input  r0_i, r1_i, rsv_i, rsv_r_i, wb0_i, wb0_r_i, result0_i,
               wb1_i, wb1_r_i, result1_i, flush_i,
        output r_opr0_o, r_opr1_o, reserved_o, rsv_full_o, busy_o
    );
endinterface

// File: rtl/g_reg_file_sb.sv
// General-register file with a saturating pending-write counter per register,
// two combinational read ports, two write-back ports and one reserve port.
module g_reg_file_sb #(
    parameter int unsigned W_OPR    = 32,
    parameter int unsigned N_REG    = 16,
    parameter int unsigned W_RD     = 4,
    parameter int unsigned PEND_W   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    g_reg_file_sb_if.slave  bus
);
    // Wide enough to hold pend + 1 and a hit count of 2 without wrapping.
    localparam int unsigned CW = ((PEND_W > 2) ? PEND_W : 2) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [W_OPR-1:0]  data_q [N_REG];
    logic [W_OPR-1:0]  data_d [N_REG];
    logic [PEND_W-1:0] pend_q [N_REG];
    logic [PEND_W-1:0] pend_d [N_REG];
    logic [N_REG-1:0]  hit0;
    logic [N_REG-1:0]  hit1;
    logic [N_REG-1:0]  inc;
    logic [CW-1:0]     sum;
    logic [CW-1:0]     dec;
    logic              rsv_full;
    logic              busy;

    function automatic logic is_zero(input logic [W_RD-1:0] idx);
        return ZERO_REG && (idx == '0);
    endfunction

    function automatic logic [W_OPR-1:0] rd_val(
        input logic             zero,
        input logic             h0,
        input logic             h1,
        input logic [W_OPR-1:0] res0,
        input logic [W_OPR-1:0] res1,
        input logic [W_OPR-1:0] stored
    );
        if (zero)
            return '0;
        if (BYPASS && h1)
            return res1;
        if (BYPASS && h0)
            return res0;
        return stored;
    endfunction

    // With forwarding, a pending write is covered when this cycle's hits retire all of it.
    function automatic logic haz(
        input logic              zero,
        input logic              h0,
        input logic              h1,
        input logic [PEND_W-1:0] pend
    );
        if (zero)
            return 1'b0;
        if (BYPASS)
            return CW'(pend) > (CW'(h0) + CW'(h1));
        return pend != '0;
    endfunction

    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            hit0[i] = bus.wb0_i && (bus.wb0_r_i == W_RD'(i));
            hit1[i] = bus.wb1_i && (bus.wb1_r_i == W_RD'(i));
        end
    end

    assign rsv_full = (pend_q[bus.rsv_r_i] == PEND_MAX) && !is_zero(bus.rsv_r_i);

    always_comb begin
        inc = '0;
        sum = '0;
        dec = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            data_d[i] = data_q[i];
            pend_d[i] = pend_q[i];
            inc[i] = bus.rsv_i && (bus.rsv_r_i == W_RD'(i)) && !rsv_full &&
                     !bus.flush_i && !is_zero(W_RD'(i));
            if (!is_zero(W_RD'(i))) begin
                if (hit1[i])
                    data_d[i] = bus.result1_i;
                else if (hit0[i])
                    data_d[i] = bus.result0_i;
            end
            sum = CW'(pend_q[i]) + CW'(inc[i]);
            dec = CW'(hit0[i]) + CW'(hit1[i]);
            if (bus.flush_i)
                pend_d[i] = '0;
            else if (sum > dec)
                pend_d[i] = PEND_W'(sum - dec);
            else
                pend_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                data_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                data_q[i] <= data_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < N_REG; i++)
            busy = busy | (pend_q[i] != '0);
    end

    // Outputs are forced low while reset is held so forwarded WB data cannot leak through.
    always_comb begin
        bus.r_opr0_o   = '0;
        bus.r_opr1_o   = '0;
        bus.reserved_o = 1'b0;
        bus.rsv_full_o = 1'b0;
        bus.busy_o     = 1'b0;
        if (reset) begin
            bus.r_opr0_o = rd_val(is_zero(bus.r0_i), hit0[bus.r0_i], hit1[bus.r0_i],
                                  bus.result0_i, bus.result1_i, data_q[bus.r0_i]);
            bus.r_opr1_o = rd_val(is_zero(bus.r1_i), hit0[bus.r1_i], hit1[bus.r1_i],
                                  bus.result0_i, bus.result1_i, data_q[bus.r1_i]);
            bus.reserved_o = haz(is_zero(bus.r0_i), hit0[bus.r0_i], hit1[bus.r0_i],
                                 pend_q[bus.r0_i]) |
                             haz(is_zero(bus.r1_i), hit0[bus.r1_i], hit1[bus.r1_i],
                                 pend_q[bus.r1_i]);
            bus.rsv_full_o = rsv_full;
            bus.busy_o     = busy;
        end
    end
endmodule
